// File: rtl/spi_cfg_master_if.sv
// Command handshake between a register-write producer and spi_cfg_master.
// The producer (master) offers one {addr, data} write per valid/ready transfer.
interface spi_cfg_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/spi_cfg_master.sv
// Host-side SPI write sequencer for the spi_peripheral register file.
// Queued {addr, data} commands are sent one per nCS frame as a 16-bit mode-0 word
// {1'b1, addr[6:0], data[7:0]}, MSB first.
module spi_cfg_master #(
    parameter int unsigned CLK_DIV    = 4,  // clk cycles per SCLK half-period, >= 2
    parameter int unsigned FIFO_DEPTH = 4,  // power of 2, >= 2
    parameter int unsigned CS_GAP     = 4   // nCS-high cycles in GAP, >= 4
) (
    input  logic                              clk,
    input  logic                              rst,
    spi_cfg_master_if.slave                   cmd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              done,
    output logic                              nCS,
    output logic                              SCLK,
    output logic                              COPI
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PhW  = $clog2(CLK_DIV);
    localparam int unsigned GapW = $clog2(CS_GAP);

    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e             state_q;
    logic [14:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic [15:0]        shreg_q;
    logic [PhW-1:0]     phase_q;
    logic [3:0]         bit_q;
    logic [GapW-1:0]    gap_q;
    logic               push;
    logic               pop;
    logic [15:0]        frame;

    assign cmd.cmd_ready = (count_q != CntFull);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state_q == StIdle) && (count_q != '0);
    assign frame         = {1'b1, mem[rd_ptr_q]};
    assign fifo_count    = count_q;
    assign busy          = (state_q != StIdle) || (count_q != '0);

    // FIFO storage; contents need no reset since count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd.cmd_addr, cmd.cmd_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame sequencer: IDLE -> SHIFT (16 bits) -> HOLD -> GAP -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shreg_q <= frame;
                        COPI    <= frame[15];
                        nCS     <= 1'b0;
                        SCLK    <= 1'b0;
                        phase_q <= '0;
                        bit_q   <= 4'd15;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (phase_q == PhLast) begin
                        phase_q <= '0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_q == 4'd0) begin
                                // Last bit: COPI keeps bit 0 through HOLD.
                                state_q <= StHold;
                            end else begin
                                bit_q   <= bit_q - 4'd1;
                                shreg_q <= {shreg_q[14:0], 1'b0};
                                COPI    <= shreg_q[14];
                            end
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StHold: begin
                    if (phase_q == PhLast) begin
                        phase_q <= '0;
                        nCS     <= 1'b1;
                        done    <= 1'b1;
                        gap_q   <= '0;
                        state_q <= StGap;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a CLK_DIV=4 instance for most scenarios and a
// CLK_DIV=2 instance for the minimum-timing loopback, both observed through one
// pin monitor and one behavioural spi_peripheral model with 2-flop input sync.
module tb_spi_cfg_master;

    logic clk = 1'b0;
    logic rst;
    logic p_rst;
    logic sel;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    spi_cfg_master_if ifc_a ();
    spi_cfg_master_if ifc_b ();

    logic [2:0] cnt_a, cnt_b;
    logic       busy_a, done_a, ncs_a, sclk_a, copi_a;
    logic       busy_b, done_b, ncs_b, sclk_b, copi_b;

    spi_cfg_master #(.CLK_DIV(4), .FIFO_DEPTH(4), .CS_GAP(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc_a.slave),
        .fifo_count (cnt_a),
        .busy       (busy_a),
        .done       (done_a),
        .nCS        (ncs_a),
        .SCLK       (sclk_a),
        .COPI       (copi_a)
    );

    spi_cfg_master #(.CLK_DIV(2), .FIFO_DEPTH(4), .CS_GAP(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc_b.slave),
        .fifo_count (cnt_b),
        .busy       (busy_b),
        .done       (done_b),
        .nCS        (ncs_b),
        .SCLK       (sclk_b),
        .COPI       (copi_b)
    );

    // Only one instance is exercised at a time; sel picks which one is observed.
    logic       ncs_m, sclk_m, copi_m, done_m, busy_m, rdy_m;
    logic [2:0] cnt_m;
    always_comb begin
        ncs_m  = sel ? ncs_b  : ncs_a;
        sclk_m = sel ? sclk_b : sclk_a;
        copi_m = sel ? copi_b : copi_a;
        done_m = sel ? done_b : done_a;
        busy_m = sel ? busy_b : busy_a;
        cnt_m  = sel ? cnt_b  : cnt_a;
        rdy_m  = sel ? ifc_b.cmd_ready : ifc_a.cmd_ready;
    end

    // Pin monitor: frames, nCS low/high run lengths, done pulses, protocol violations.
    int          cyc = 0;
    int          low_run = 0;
    int          high_run = 1000;
    int          last_low = 0;
    int          last_period = 0;
    int          fall_cyc = 0;
    int          mon_bits = 0;
    int          short_cnt = 0;
    int          done_cnt = 0;
    int          edge_viol = 0;
    int          copi_viol = 0;
    logic [15:0] mon_sh = '0;
    logic [15:0] frames [$];
    int          gaps [$];
    logic        ncs_p = 1'b1;
    logic        sclk_p = 1'b0;
    logic        copi_p = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            cyc = cyc + 1;
            if (!ncs_m && ncs_p) begin
                last_period = cyc - fall_cyc;
                fall_cyc    = cyc;
                gaps.push_back(high_run);
                low_run  = 0;
                mon_bits = 0;
                mon_sh   = '0;
            end
            if (ncs_m && !ncs_p) begin
                if (mon_bits == 16) frames.push_back(mon_sh);
                else short_cnt = short_cnt + 1;
                last_low = low_run;
                high_run = 0;
            end
            if (!ncs_m) begin
                low_run = low_run + 1;
                if (sclk_m && !sclk_p) begin
                    mon_sh   = {mon_sh[14:0], copi_m};
                    mon_bits = mon_bits + 1;
                end
            end else begin
                high_run = high_run + 1;
            end
            if (done_m) done_cnt = done_cnt + 1;
            if (ncs_m && ncs_p && (sclk_m != sclk_p)) edge_viol = edge_viol + 1;
            if (sclk_m && sclk_p && (copi_m != copi_p)) copi_viol = copi_viol + 1;
        end
        ncs_p  = ncs_m;
        sclk_p = sclk_m;
        copi_p = copi_m;
    end

    // Behavioural spi_peripheral: 2-flop sync, sample on synced SCLK rise, commit on nCS rise.
    logic [1:0]  s_ncs, s_sclk, s_copi;
    logic        d_ncs, d_sclk;
    logic [15:0] p_sh;
    logic [4:0]  p_cnt;
    logic [7:0]  preg [5];

    always @(posedge clk or posedge p_rst) begin
        if (p_rst) begin
            s_ncs  <= 2'b11;
            s_sclk <= 2'b00;
            s_copi <= 2'b00;
            d_ncs  <= 1'b1;
            d_sclk <= 1'b0;
            p_sh   <= '0;
            p_cnt  <= '0;
            for (int i = 0; i < 5; i++) preg[i] <= 8'h00;
        end else begin
            s_ncs  <= {s_ncs[0], ncs_m};
            s_sclk <= {s_sclk[0], sclk_m};
            s_copi <= {s_copi[0], copi_m};
            d_ncs  <= s_ncs[1];
            d_sclk <= s_sclk[1];
            if (!s_ncs[1] && d_ncs) begin
                p_cnt <= '0;
                p_sh  <= '0;
            end else if (!s_ncs[1] && s_sclk[1] && !d_sclk) begin
                p_sh  <= {p_sh[14:0], s_copi[1]};
                p_cnt <= p_cnt + 5'd1;
            end
            if (s_ncs[1] && !d_ncs && (p_cnt == 5'd16) && p_sh[15]) begin
                case (p_sh[14:8])
                    7'd0:    preg[0] <= p_sh[7:0];
                    7'd1:    preg[1] <= p_sh[7:0];
                    7'd2:    preg[2] <= p_sh[7:0];
                    7'd3:    preg[3] <= p_sh[7:0];
                    7'd4:    preg[4] <= p_sh[7:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] a, input logic [7:0] d);
        if (sel) begin
            ifc_b.cmd_valid = v;
            ifc_b.cmd_addr  = a;
            ifc_b.cmd_data  = d;
        end else begin
            ifc_a.cmd_valid = v;
            ifc_a.cmd_addr  = a;
            ifc_a.cmd_data  = d;
        end
    endtask

    // One-cycle push; waits (bounded) for cmd_ready.
    task automatic push(input logic [6:0] a, input logic [7:0] d);
        int guard = 0;
        drive(1'b1, a, d);
        while (!rdy_m && guard < 2000) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL push_ready: cmd_ready=%0b required 1", rdy_m);
        end
        tick();
        drive(1'b0, 7'h00, 8'h00);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy_m || !ncs_m) && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b nCS=%0b required 0/1", busy_m, ncs_m);
        end
    endtask

    task automatic test_reset();
        sel   = 1'b0;
        rst   = 1'b1;
        p_rst = 1'b1;
        ifc_a.cmd_valid = 1'b0; ifc_a.cmd_addr = '0; ifc_a.cmd_data = '0;
        ifc_b.cmd_valid = 1'b0; ifc_b.cmd_addr = '0; ifc_b.cmd_data = '0;
        repeat (3) tick();
        checks++; if (ncs_m !== 1'b1) begin errors++; $display("FAIL rst_ncs: got %b want 1", ncs_m); end
        checks++; if (sclk_m !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", sclk_m); end
        checks++; if (copi_m !== 1'b0) begin errors++; $display("FAIL rst_copi: got %b want 0", copi_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_m); end
        checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cnt_m); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", rdy_m); end
        rst   = 1'b0;
        p_rst = 1'b0;
        repeat (3) tick();
    endtask

    // T1: single frame 0x00 <- 0xA5.
    task automatic test_single_frame();
        int n0 = frames.size();
        int d0 = done_cnt;
        int k  = 0;
        push(7'h00, 8'hA5);
        checks++; if (cnt_m !== 3'd1) begin errors++; $display("FAIL t1_count: got %0d want 1", cnt_m); end
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy_m); end
        while (!done_m && k < 300) begin
            tick();
            k++;
        end
        checks++; if (k >= 300) begin errors++; $display("FAIL t1_done_seen: got 0 want 1"); end
        k = 0;
        while (busy_m && k < 100) begin
            k++;
            tick();
        end
        checks++; if (k != 4) begin errors++; $display("FAIL t1_busy_tail: got %0d want 4", k); end
        repeat (4) tick();
        checks++;
        if (frames.size() != n0 + 1) begin
            errors++; $display("FAIL t1_frames: got %0d want %0d", frames.size(), n0 + 1);
        end else if (frames[n0] !== 16'h80A5) begin
            errors++; $display("FAIL t1_frame: got %h want 80a5", frames[n0]);
        end
        checks++; if (last_low != 132) begin errors++; $display("FAIL t1_ncs_low: got %0d want 132", last_low); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    // T2: loopback writes reach the peripheral after their own frames.
    task automatic test_loopback();
        int k = 0;
        push(7'h04, 8'h80);
        push(7'h02, 8'h0F);
        while (!done_m && k < 300) begin
            tick();
            k++;
        end
        repeat (6) tick();
        checks++; if (preg[4] !== 8'h80) begin errors++; $display("FAIL t2_duty: got %h want 80", preg[4]); end
        checks++; if (preg[2] !== 8'h00) begin errors++; $display("FAIL t2_pwm_early: got %h want 00", preg[2]); end
        wait_idle(400);
        repeat (6) tick();
        checks++; if (preg[2] !== 8'h0F) begin errors++; $display("FAIL t2_pwm: got %h want 0f", preg[2]); end
    endtask

    // T3: six commands with cmd_valid held high against a 4-deep FIFO.
    logic [14:0] t3_cmd [6];
    logic [15:0] t3_frame [6];

    task automatic test_back_to_back();
        int n0 = frames.size();
        int g0 = gaps.size();
        int i = 0;
        int guard = 0;
        int bad = 0;
        int min_g = 1000;
        logic saw_full = 1'b0;
        t3_cmd[0] = 15'h0011; t3_frame[0] = 16'h8011;
        t3_cmd[1] = 15'h0122; t3_frame[1] = 16'h8122;
        t3_cmd[2] = 15'h0344; t3_frame[2] = 16'h8344;
        t3_cmd[3] = 15'h0455; t3_frame[3] = 16'h8455;
        t3_cmd[4] = 15'h0566; t3_frame[4] = 16'h8566;
        t3_cmd[5] = 15'h0277; t3_frame[5] = 16'h8277;
        while (i < 6 && guard < 3000) begin
            drive(1'b1, t3_cmd[i][14:8], t3_cmd[i][7:0]);
            if (cnt_m == 3'd4) begin
                saw_full = 1'b1;
                if (rdy_m) bad++;
            end
            if (rdy_m) i++;
            tick();
            guard++;
        end
        drive(1'b0, 7'h00, 8'h00);
        checks++; if (!saw_full) begin errors++; $display("FAIL t3_full: got 0 want 1"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL t3_ready_when_full: got %0d want 0", bad); end
        wait_idle(2000);
        repeat (6) tick();
        checks++;
        if (frames.size() != n0 + 6) begin
            errors++; $display("FAIL t3_frames: got %0d want %0d", frames.size(), n0 + 6);
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (frames[n0+j] !== t3_frame[j]) begin
                    errors++; $display("FAIL t3_frame%0d: got %h want %h", j, frames[n0+j], t3_frame[j]);
                end
            end
        end
        for (int j = g0 + 1; j < gaps.size(); j++) begin
            if (gaps[j] < min_g) min_g = gaps[j];
        end
        checks++; if (min_g < 4) begin errors++; $display("FAIL t3_min_gap: got %0d want >=4", min_g); end
        checks++; if (last_period != 137) begin errors++; $display("FAIL t3_period: got %0d want 137", last_period); end
        checks++;
        if ({preg[0], preg[1], preg[2], preg[3], preg[4]} !== 40'h1122774455) begin
            errors++; $display("FAIL t3_regs: got %h want 1122774455", {preg[0], preg[1], preg[2], preg[3], preg[4]});
        end
    endtask

    // T4: out-of-range address is forwarded unchanged and ignored by the peripheral.
    task automatic test_bad_addr();
        int n0 = frames.size();
        push(7'h7F, 8'hFF);
        wait_idle(400);
        repeat (6) tick();
        checks++;
        if (frames.size() != n0 + 1) begin
            errors++; $display("FAIL t4_frames: got %0d want %0d", frames.size(), n0 + 1);
        end else if (frames[n0] !== 16'hFFFF) begin
            errors++; $display("FAIL t4_frame: got %h want ffff", frames[n0]);
        end
        checks++;
        if ({preg[0], preg[1], preg[2], preg[3], preg[4]} !== 40'h1122774455) begin
            errors++; $display("FAIL t4_regs: got %h want 1122774455", {preg[0], preg[1], preg[2], preg[3], preg[4]});
        end
    endtask

    // T5: reset during bit 7 with two commands queued.
    task automatic test_reset_mid_frame();
        int n0 = frames.size();
        int d0 = done_cnt;
        int g1;
        int k = 0;
        push(7'h00, 8'hDE);
        push(7'h01, 8'hAD);
        push(7'h02, 8'hBE);
        while ((ncs_m || mon_bits < 9) && k < 500) begin
            tick();
            k++;
        end
        checks++; if (k >= 500) begin errors++; $display("FAIL t5_reach_bit7: got timeout want bit 7"); end
        checks++; if (cnt_m !== 3'd2) begin errors++; $display("FAIL t5_queued: got %0d want 2", cnt_m); end
        rst = 1'b1;
        #1;
        checks++; if (ncs_m !== 1'b1) begin errors++; $display("FAIL t5_ncs: got %b want 1", ncs_m); end
        checks++; if (sclk_m !== 1'b0) begin errors++; $display("FAIL t5_sclk: got %b want 0", sclk_m); end
        checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL t5_count: got %0d want 0", cnt_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL t5_done: got %b want 0", done_m); end
        repeat (2) tick();
        rst = 1'b0;
        g1 = gaps.size();
        repeat (200) tick();
        checks++; if (gaps.size() != g1) begin errors++; $display("FAIL t5_no_frame: got %0d want %0d", gaps.size(), g1); end
        checks++; if (frames.size() != n0) begin errors++; $display("FAIL t5_no_full_frame: got %0d want %0d", frames.size(), n0); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL t5_no_done: got %0d want %0d", done_cnt, d0); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy_m); end
        push(7'h01, 8'h99);
        wait_idle(400);
        repeat (6) tick();
        checks++;
        if (frames.size() != n0 + 1) begin
            errors++; $display("FAIL t5_resume: got %0d want %0d", frames.size(), n0 + 1);
        end else if (frames[n0] !== 16'h8199) begin
            errors++; $display("FAIL t5_resume_frame: got %h want 8199", frames[n0]);
        end
        checks++;
        if ({preg[0], preg[1], preg[2], preg[3], preg[4]} !== 40'h1199774455) begin
            errors++; $display("FAIL t5_regs: got %h want 1199774455", {preg[0], preg[1], preg[2], preg[3], preg[4]});
        end
    endtask

    // T6: CLK_DIV=2 instance against the synchronising peripheral.
    task automatic test_min_timing();
        sel = 1'b1;
        repeat (4) tick();
        push(7'h00, 8'h3C);
        push(7'h03, 8'h5A);
        push(7'h04, 8'hC3);
        wait_idle(1000);
        repeat (6) tick();
        checks++;
        if ({preg[0], preg[1], preg[2], preg[3], preg[4]} !== 40'h3C99775AC3) begin
            errors++; $display("FAIL t6_regs: got %h want 3c99775ac3", {preg[0], preg[1], preg[2], preg[3], preg[4]});
        end
        checks++; if (last_low != 66) begin errors++; $display("FAIL t6_ncs_low: got %0d want 66", last_low); end
        checks++; if (last_period != 71) begin errors++; $display("FAIL t6_period: got %0d want 71", last_period); end
        checks++; if (edge_viol != 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d want 0", edge_viol); end
        checks++; if (copi_viol != 0) begin errors++; $display("FAIL copi_while_sclk_high: got %0d want 0", copi_viol); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_loopback();
        test_back_to_back();
        test_bad_addr();
        test_reset_mid_frame();
        test_min_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "global timeout");
    end

endmodule
